// File: rtl/control_unit.sv
// Main decoder for a single-cycle RV32I datapath.
// Control outputs are combinational; a sticky flag records illegal encodings.
module control_unit #(
    parameter int unsigned OP_EFF_WIDTH  = 5,
    parameter int unsigned FUNCT3_WIDTH  = 3,
    parameter int unsigned ALUCTRL_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [OP_EFF_WIDTH-1:0]  opcode_eff,
    input  logic                     funct7_fif,
    input  logic [FUNCT3_WIDTH-1:0]  funct3,
    input  logic                     BrEq,
    input  logic                     BrLT,
    output logic                     PCSel,
    output logic [2:0]               ImmSel,
    output logic                     RegWEn,
    output logic                     BrUn,
    output logic                     ASel,
    output logic                     BSel,
    output logic [ALUCTRL_WIDTH-1:0] ALUSel,
    output logic                     MemRW,
    output logic [1:0]               WBSel,
    output logic                     illegal_instr,
    output logic                     illegal_seen
);

    // Effective opcodes (instruction bits [6:2])
    localparam logic [OP_EFF_WIDTH-1:0] OP_LOAD   = 5'b00000;
    localparam logic [OP_EFF_WIDTH-1:0] OP_IARITH = 5'b00100;
    localparam logic [OP_EFF_WIDTH-1:0] OP_AUIPC  = 5'b00101;
    localparam logic [OP_EFF_WIDTH-1:0] OP_STORE  = 5'b01000;
    localparam logic [OP_EFF_WIDTH-1:0] OP_RTYPE  = 5'b01100;
    localparam logic [OP_EFF_WIDTH-1:0] OP_LUI    = 5'b01101;
    localparam logic [OP_EFF_WIDTH-1:0] OP_BRANCH = 5'b11000;
    localparam logic [OP_EFF_WIDTH-1:0] OP_JALR   = 5'b11001;
    localparam logic [OP_EFF_WIDTH-1:0] OP_JAL    = 5'b11011;

    localparam logic [ALUCTRL_WIDTH-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_AND  = 4'd2;
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_OR   = 4'd3;
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLL  = 4'd5;
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLT  = 4'd8;
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLTU = 4'd9;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    logic [ALUCTRL_WIDTH-1:0] alu_f3;

    // Base ALU operation implied by funct3, before the bit-30 modifier
    always_comb begin
        alu_f3 = ALU_ADD;
        unique case (funct3)
            3'b000: alu_f3 = ALU_ADD;
            3'b001: alu_f3 = ALU_SLL;
            3'b010: alu_f3 = ALU_SLT;
            3'b011: alu_f3 = ALU_SLTU;
            3'b100: alu_f3 = ALU_XOR;
            3'b101: alu_f3 = ALU_SRL;
            3'b110: alu_f3 = ALU_OR;
            3'b111: alu_f3 = ALU_AND;
            default: alu_f3 = ALU_ADD;
        endcase
    end

    // Main decode; every control defaults to 0 so unsupported encodings do nothing
    always_comb begin
        PCSel         = 1'b0;
        ImmSel        = IMM_I;
        RegWEn        = 1'b0;
        BrUn          = 1'b0;
        ASel          = 1'b0;
        BSel          = 1'b0;
        ALUSel        = ALU_ADD;
        MemRW         = 1'b0;
        WBSel         = WB_MEM;
        illegal_instr = 1'b0;
        case (opcode_eff)
            OP_RTYPE: begin
                ALUSel = alu_f3;
                if (funct7_fif && funct3 == 3'b000) ALUSel = ALU_SUB;
                if (funct7_fif && funct3 == 3'b101) ALUSel = ALU_SRA;
                RegWEn = 1'b1;
                WBSel  = WB_ALU;
            end
            OP_IARITH: begin
                // Bit 30 is part of the immediate except for SRAI, so ADDI never subtracts
                ALUSel = alu_f3;
                if (funct7_fif && funct3 == 3'b101) ALUSel = ALU_SRA;
                BSel   = 1'b1;
                RegWEn = 1'b1;
                WBSel  = WB_ALU;
            end
            OP_LOAD: begin
                BSel   = 1'b1;
                RegWEn = 1'b1;
                WBSel  = WB_MEM;
            end
            OP_STORE: begin
                BSel   = 1'b1;
                MemRW  = 1'b1;
                ImmSel = IMM_S;
            end
            OP_BRANCH: begin
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    illegal_instr = 1'b1;
                end else begin
                    ASel   = 1'b1;
                    BSel   = 1'b1;
                    ImmSel = IMM_B;
                    BrUn   = funct3[1];
                    unique case (funct3)
                        3'b000:         PCSel = BrEq;
                        3'b001:         PCSel = ~BrEq;
                        3'b100, 3'b110: PCSel = BrLT;
                        3'b101, 3'b111: PCSel = ~BrLT;
                        default:        PCSel = 1'b0;
                    endcase
                end
            end
            OP_JAL: begin
                PCSel  = 1'b1;
                ASel   = 1'b1;
                BSel   = 1'b1;
                ImmSel = IMM_J;
                RegWEn = 1'b1;
                WBSel  = WB_PC4;
            end
            OP_JALR: begin
                PCSel  = 1'b1;
                BSel   = 1'b1;
                ImmSel = IMM_I;
                RegWEn = 1'b1;
                WBSel  = WB_PC4;
            end
            OP_AUIPC: begin
                ASel   = 1'b1;
                BSel   = 1'b1;
                ImmSel = IMM_U;
                RegWEn = 1'b1;
                WBSel  = WB_ALU;
            end
            OP_LUI: begin
                ImmSel = IMM_U;
                RegWEn = 1'b1;
                WBSel  = WB_IMM;
            end
            default: illegal_instr = 1'b1;
        endcase
    end

    // Sticky illegal-encoding flag; reset has priority over a coincident illegal encoding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_seen <= 1'b0;
        end else if (illegal_instr) begin
            illegal_seen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed sweeps plus randomized decode
// checked against a table-driven reference model.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] opcode_eff;
    logic       funct7_fif;
    logic [2:0] funct3;
    logic       BrEq, BrLT;
    logic       PCSel, RegWEn, BrUn, ASel, BSel, MemRW, illegal_instr, illegal_seen;
    logic [2:0] ImmSel;
    logic [3:0] ALUSel;
    logic [1:0] WBSel;

    int n_checks = 0;
    int n_fail   = 0;
    logic seen_m = 1'b0;

    localparam int unsigned ALU_MAP [8] = '{0, 5, 8, 9, 4, 6, 3, 2};
    localparam logic [4:0] LEGAL_OPS [9] = '{5'b00000, 5'b00100, 5'b01000, 5'b01100, 5'b00101,
                                             5'b01101, 5'b11000, 5'b11001, 5'b11011};

    control_unit dut (
        .clk          (clk),
        .rst          (rst),
        .opcode_eff   (opcode_eff),
        .funct7_fif   (funct7_fif),
        .funct3       (funct3),
        .BrEq         (BrEq),
        .BrLT         (BrLT),
        .PCSel        (PCSel),
        .ImmSel       (ImmSel),
        .RegWEn       (RegWEn),
        .BrUn         (BrUn),
        .ASel         (ASel),
        .BSel         (BSel),
        .ALUSel       (ALUSel),
        .MemRW        (MemRW),
        .WBSel        (WBSel),
        .illegal_instr(illegal_instr),
        .illegal_seen (illegal_seen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {PCSel, ImmSel, RegWEn, BrUn, ASel, BSel, ALUSel, MemRW, WBSel, illegal}
    function automatic logic [15:0] model(input logic [4:0] op, input logic [2:0] f3,
                                          input logic fif, input logic eq, input logic lt);
        logic       pc = 0, rw = 0, bru = 0, as = 0, bs = 0, mw = 0, ill = 0;
        logic [2:0] imm = 0;
        logic [1:0] wb = 0;
        int unsigned alu = 0;
        case (op)
            5'b01100, 5'b00100: begin
                alu = ALU_MAP[f3];
                if (fif && f3 == 3'd5) alu = 7;
                if (fif && f3 == 3'd0 && op == 5'b01100) alu = 1;
                bs = (op == 5'b00100);
                rw = 1; wb = 2'b01;
            end
            5'b00000: begin bs = 1; rw = 1; end
            5'b01000: begin bs = 1; mw = 1; imm = 3'b001; end
            5'b11000: begin
                if (f3 == 3'd2 || f3 == 3'd3) ill = 1;
                else begin
                    as = 1; bs = 1; imm = 3'b010; bru = f3[1];
                    // f3[2] picks less-than vs equal, f3[0] inverts the sense
                    pc = (f3[2] ? lt : eq) ^ f3[0];
                end
            end
            5'b11011: begin pc = 1; as = 1; bs = 1; imm = 3'b011; rw = 1; wb = 2'b10; end
            5'b11001: begin pc = 1; bs = 1; rw = 1; wb = 2'b10; end
            5'b00101: begin as = 1; bs = 1; imm = 3'b100; rw = 1; wb = 2'b01; end
            5'b01101: begin imm = 3'b100; rw = 1; wb = 2'b11; end
            default:  ill = 1;
        endcase
        return {pc, imm, rw, bru, as, bs, alu[3:0], mw, wb, ill};
    endfunction

    // Drive one encoding, check decode mid-cycle, then check the sticky flag after the edge
    task automatic apply(input logic [4:0] op, input logic [2:0] f3, input logic fif,
                         input logic eq, input logic lt);
        logic [15:0] exp;
        opcode_eff = op; funct3 = f3; funct7_fif = fif; BrEq = eq; BrLT = lt;
        #2;
        exp = model(op, f3, fif, eq, lt);
        check($sformatf("ctrl op=%b f3=%b fif=%b eq=%b lt=%b", op, f3, fif, eq, lt),
              {16'h0, PCSel, ImmSel, RegWEn, BrUn, ASel, BSel, ALUSel, MemRW, WBSel,
               illegal_instr},
              {16'h0, exp});
        seen_m = seen_m | exp[0];
        @(posedge clk);
        #1;
        check("illegal_seen", {31'h0, illegal_seen}, {31'h0, seen_m});
    endtask

    initial begin
        rst = 1'b1;
        opcode_eff = 5'b11111; funct3 = 3'd0; funct7_fif = 1'b0; BrEq = 1'b0; BrLT = 1'b0;
        #2;
        check("reset illegal_seen", {31'h0, illegal_seen}, 32'h0);
        // Illegal encoding present across an edge while in reset: reset wins
        @(posedge clk);
        #1;
        check("reset wins", {31'h0, illegal_seen}, 32'h0);
        rst = 1'b0;

        // R-type and I-arith sweeps, both bit-30 values
        for (int f = 0; f < 8; f++) begin
            for (int b = 0; b < 2; b++) begin
                apply(5'b01100, 3'(f), 1'(b), 1'b0, 1'b0);
                apply(5'b00100, 3'(f), 1'(b), 1'b0, 1'b0);
            end
        end
        apply(5'b00000, 3'd2, 1'b0, 1'b0, 1'b0);
        apply(5'b01000, 3'd2, 1'b0, 1'b0, 1'b0);
        apply(5'b11011, 3'd0, 1'b0, 1'b1, 1'b1);
        apply(5'b11001, 3'd0, 1'b0, 1'b1, 1'b1);
        apply(5'b00101, 3'd0, 1'b0, 1'b0, 1'b0);
        apply(5'b01101, 3'd0, 1'b0, 1'b0, 1'b0);
        // Legal branches against every comparator combination
        for (int f = 0; f < 8; f++) begin
            if (f == 2 || f == 3) continue;
            for (int c = 0; c < 4; c++) apply(5'b11000, 3'(f), 1'b0, c[1], c[0]);
        end
        check("no illegal yet", {31'h0, illegal_seen}, 32'h0);

        // Unsupported opcode sets the flag, which then holds on legal traffic
        apply(5'b11111, 3'd0, 1'b0, 1'b1, 1'b1);
        apply(5'b01100, 3'd0, 1'b0, 1'b0, 1'b0);
        apply(5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);

        // Mid-cycle reset clears immediately and holds through an illegal edge
        opcode_eff = 5'b11111;
        rst = 1'b1;
        #1;
        check("async clear", {31'h0, illegal_seen}, 32'h0);
        @(posedge clk);
        #1;
        check("reset wins held", {31'h0, illegal_seen}, 32'h0);
        rst = 1'b0;
        seen_m = 1'b0;

        // Reserved branch funct3 is illegal too
        apply(5'b11000, 3'd2, 1'b0, 1'b1, 1'b0);
        apply(5'b11000, 3'd3, 1'b0, 1'b0, 1'b1);

        // Randomized decode, with periodic reset pulses so the flag is exercised repeatedly
        for (int i = 0; i < 400; i++) begin
            logic [4:0] op;
            if (i % 50 == 0) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
                seen_m = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) op = 5'($urandom);
            else op = LEGAL_OPS[$urandom_range(0, 8)];
            apply(op, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
